// File: rtl/fft_pkg.sv
// Shared constants and the FSM state type for the FFT spectrum-magnitude path.
package fft_pkg;

    localparam int DATA_WIDTH = 21;
    localparam int FRAC_BITS  = 15;
    localparam int N_BINS     = 8;

    // 1/K of the CORDIC gain in Q0.16 (K ~= 1.64676)
    localparam logic [16:0] CORDIC_INV_GAIN = 17'd39797;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        SCALE,
        OUT
    } state_t;

endpackage

// File: rtl/cordic_vec_iter.sv
// One vectoring-mode CORDIC micro-rotation; drives y toward zero.
module cordic_vec_iter #(
    parameter int W  = 23,
    parameter int SW = 5
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic        [SW-1:0] shift,
    output logic signed [W-1:0]  x_nxt,
    output logic signed [W-1:0]  y_nxt
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;

    assign xs = x >>> shift;
    assign ys = y >>> shift;

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (!y[W-1]) begin
            x_nxt = x + ys;
            y_nxt = y - xs;
        end else begin
            x_nxt = x - ys;
            y_nxt = y + xs;
        end
    end

endmodule

// File: rtl/fft_mag_cordic.sv
// Per-bin magnitude of an FFT frame using one shared iterative CORDIC;
// magnitudes stream out bin 0 first on a valid/ready interface.
module fft_mag_cordic
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 21,
    parameter int N_BINS     = 8,
    parameter int ITERS      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [N_BINS-1:0][DATA_WIDTH-1:0]    y_re_i,
    input  logic [N_BINS-1:0][DATA_WIDTH-1:0]    y_im_i,
    output logic                                 mag_valid_o,
    input  logic                                 mag_ready_i,
    output logic [DATA_WIDTH:0]                  mag_o,
    output logic [2:0]                           mag_idx_o,
    output logic                                 mag_last_o
);

    // Two guard bits: one for the -2^20 fold, one for CORDIC gain growth.
    localparam int W  = DATA_WIDTH + 2;
    localparam int IW = $clog2(DATA_WIDTH + 1);

    state_t                            state;
    logic [N_BINS-1:0][DATA_WIDTH-1:0] re_buf;
    logic [N_BINS-1:0][DATA_WIDTH-1:0] im_buf;
    logic [2:0]                        cnt;
    logic [IW-1:0]                     it;
    logic signed [W-1:0]               x;
    logic signed [W-1:0]               y;
    logic signed [W-1:0]               x_nxt;
    logic signed [W-1:0]               y_nxt;
    logic signed [W-1:0]               ext_re;
    logic signed [W-1:0]               ext_im;
    logic signed [W+17:0]              prod;
    logic                              unused_prod;

    assign ext_re = {{2{re_buf[cnt][DATA_WIDTH-1]}}, re_buf[cnt]};
    assign ext_im = {{2{im_buf[cnt][DATA_WIDTH-1]}}, im_buf[cnt]};

    assign prod        = x * $signed({1'b0, CORDIC_INV_GAIN});
    assign unused_prod = ^{prod[W+17:DATA_WIDTH+17], prod[15:0]};

    cordic_vec_iter #(
        .W  (W),
        .SW (IW)
    ) u_iter (
        .x     (x),
        .y     (y),
        .shift (it),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ready_o     <= 1'b1;
            mag_valid_o <= 1'b0;
            mag_o       <= '0;
            mag_idx_o   <= '0;
            mag_last_o  <= 1'b0;
            re_buf      <= '0;
            im_buf      <= '0;
            cnt         <= '0;
            it          <= '0;
            x           <= '0;
            y           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        re_buf  <= y_re_i;
                        im_buf  <= y_im_i;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Fold into the right half-plane so vectoring converges.
                    if (ext_re[W-1]) begin
                        x <= -ext_re;
                        y <= -ext_im;
                    end else begin
                        x <= ext_re;
                        y <= ext_im;
                    end
                    it    <= '0;
                    state <= ITER;
                end
                ITER: begin
                    x  <= x_nxt;
                    y  <= y_nxt;
                    it <= it + 1'b1;
                    if (it == IW'(ITERS - 1)) state <= SCALE;
                end
                SCALE: begin
                    mag_o       <= prod[DATA_WIDTH+16:16];
                    mag_idx_o   <= cnt;
                    mag_last_o  <= (cnt == 3'(N_BINS - 1));
                    mag_valid_o <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (mag_ready_i) begin
                        mag_valid_o <= 1'b0;
                        if (cnt == 3'(N_BINS - 1)) begin
                            ready_o <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt   <= cnt + 3'd1;
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_mag_cordic.sv
// Scoreboard bench for fft_mag_cordic: expected magnitudes come from sqrt().
module tb_fft_mag_cordic;

    localparam int DW = 21;
    localparam int NB = 8;
    localparam int IT = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid_i = 1'b0;
    logic                   ready_o;
    logic [NB-1:0][DW-1:0]  y_re = '0;
    logic [NB-1:0][DW-1:0]  y_im = '0;
    logic                   mag_valid_o;
    logic                   mag_ready_i = 1'b1;
    logic [DW:0]            mag_o;
    logic [2:0]             mag_idx_o;
    logic                   mag_last_o;

    fft_mag_cordic #(
        .DATA_WIDTH (DW),
        .N_BINS     (NB),
        .ITERS      (IT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .y_re_i      (y_re),
        .y_im_i      (y_im),
        .mag_valid_o (mag_valid_o),
        .mag_ready_i (mag_ready_i),
        .mag_o       (mag_o),
        .mag_idx_o   (mag_idx_o),
        .mag_last_o  (mag_last_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int  idx;
        real mag;
        bit  last;
        int  tol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   acc;
    int   vcyc [NB];
    bit   rdy_v [NB];

    function automatic real true_mag(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int ia;
        int ib;
        real ra;
        real rb;
        ia = int'($signed(a));
        ib = int'($signed(b));
        ra = real'(ia);
        rb = real'(ib);
        return $sqrt(ra * ra + rb * rb);
    endfunction

    // Waits for ready_o, presents the frame for one accept edge, queues expectations.
    task automatic send_frame(input logic [NB-1:0][DW-1:0] re, input logic [NB-1:0][DW-1:0] im,
                              input int tol);
        int  k;
        real m;
        k = 0;
        while (!ready_o && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (ready_o !== 1'b1) begin
            $display("FAIL send_ready got=%0b want=1", ready_o);
            failures++;
        end
        y_re    = re;
        y_im    = im;
        valid_i = 1'b1;
        for (int b = 0; b < NB; b++) begin
            m = true_mag(re[b], im[b]);
            sb.push_back('{idx: b, mag: m, last: (b == NB - 1), tol: (m == 0.0) ? 0 : tol});
        end
        @(posedge clk); #1;
        acc     = cyc;
        valid_i = 1'b0;
    endtask

    // Pops and compares n beats; stalls mag_ready_i for 10 cycles on bin stall_idx.
    task automatic collect(input int n, input int stall_idx);
        int          k;
        exp_t        e;
        real         d;
        logic [DW:0] m0;
        logic [2:0]  i0;
        logic        l0;
        for (int b = 0; b < n; b++) begin
            k = 0;
            while (!mag_valid_o && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            checks++;
            if (mag_valid_o !== 1'b1) begin
                $display("FAIL collect_timeout bin=%0d got valid=%0b want 1", b, mag_valid_o);
                failures++;
                sb.delete();
                return;
            end
            vcyc[b]  = cyc - acc;
            rdy_v[b] = ready_o;
            e = sb.pop_front();
            checks++;
            if (mag_idx_o !== 3'(e.idx)) begin
                $display("FAIL mag_idx got=%0d want=%0d", mag_idx_o, e.idx);
                failures++;
            end
            checks++;
            if (mag_last_o !== e.last) begin
                $display("FAIL mag_last idx=%0d got=%0b want=%0b", e.idx, mag_last_o, e.last);
                failures++;
            end
            d = real'(int'(mag_o)) - e.mag;
            if (d < 0.0) d = -d;
            checks++;
            if (d > real'(e.tol) || $isunknown(mag_o)) begin
                $display("FAIL mag_value idx=%0d got=%0d want=%0.2f tol=%0d", e.idx, mag_o, e.mag, e.tol);
                failures++;
            end
            if (b == stall_idx) begin
                m0 = mag_o;
                i0 = mag_idx_o;
                l0 = mag_last_o;
                mag_ready_i = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    checks++;
                    if (mag_valid_o !== 1'b1 || mag_o !== m0 || mag_idx_o !== i0 || mag_last_o !== l0) begin
                        $display("FAIL stall_hold got v=%0b m=%0d i=%0d want v=1 m=%0d i=%0d",
                                 mag_valid_o, mag_o, mag_idx_o, m0, i0);
                        failures++;
                    end
                end
                mag_ready_i = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_frame(output logic [NB-1:0][DW-1:0] re, output logic [NB-1:0][DW-1:0] im);
        int v;
        for (int b = 0; b < NB; b++) begin
            v = int'($urandom_range(0, 1048575)) - 524288;
            re[b] = DW'(v);
            v = int'($urandom_range(0, 1048575)) - 524288;
            im[b] = DW'(v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ready_o !== 1'b1 || mag_valid_o !== 1'b0 || mag_o !== '0 || mag_idx_o !== 3'd0 || mag_last_o !== 1'b0) begin
            $display("FAIL %s got rdy=%0b v=%0b m=%0d i=%0d l=%0b want rdy=1 v=0 m=0 i=0 l=0",
                     tag, ready_o, mag_valid_o, mag_o, mag_idx_o, mag_last_o);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_three_four();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        re = '0;
        im = '0;
        re[0] = 21'h18000;
        im[0] = 21'h20000;
        send_frame(re, im, 4);
        collect(NB, -1);
    endtask

    task automatic test_neg_axis();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        re = '0;
        im = '0;
        re[3] = 21'h1F8000;
        im[5] = 21'h1F8000;
        send_frame(re, im, 4);
        collect(NB, -1);
    endtask

    task automatic test_corner();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        for (int b = 0; b < NB; b++) begin
            re[b] = 21'h100000;
            im[b] = 21'h100000;
        end
        send_frame(re, im, 8);
        collect(NB, -1);
    endtask

    task automatic test_timing();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        rand_frame(re, im);
        send_frame(re, im, 4);
        repeat (5) @(posedge clk);
        #1;
        y_re    = ~re;
        y_im    = re;
        valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        valid_i = 1'b0;
        collect(NB, -1);
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (vcyc[b] != (IT + 2) + (IT + 3) * b) begin
                $display("FAIL valid_cycle bin=%0d got=%0d want=%0d", b, vcyc[b], (IT + 2) + (IT + 3) * b);
                failures++;
            end
        end
        checks++;
        if (rdy_v[NB-1] !== 1'b0) begin
            $display("FAIL ready_busy got=%0b want=0", rdy_v[NB-1]);
            failures++;
        end
        checks++;
        if (ready_o !== 1'b1 || (cyc - acc) != NB * (IT + 3)) begin
            $display("FAIL ready_return got rdy=%0b at=%0d want rdy=1 at=%0d", ready_o, cyc - acc, NB * (IT + 3));
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        int a0;
        rand_frame(re, im);
        send_frame(re, im, 4);
        a0 = acc;
        collect(NB, -1);
        rand_frame(re, im);
        send_frame(re, im, 4);
        checks++;
        if (acc - a0 != NB * (IT + 3) + 1) begin
            $display("FAIL accept_gap got=%0d want=%0d", acc - a0, NB * (IT + 3) + 1);
            failures++;
        end
        collect(NB, -1);
    endtask

    task automatic test_backpressure();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        rand_frame(re, im);
        send_frame(re, im, 4);
        collect(NB, 2);
    endtask

    task automatic test_mid_reset();
        logic [NB-1:0][DW-1:0] re;
        logic [NB-1:0][DW-1:0] im;
        bit seen;
        rand_frame(re, im);
        send_frame(re, im, 4);
        collect(4, -1);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mag_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            $display("FAIL post_reset_valid got valid=1 want 0");
            failures++;
        end
        re = '0;
        im = '0;
        re[0] = 21'h18000;
        im[0] = 21'h20000;
        re[6] = 21'h1F8000;
        send_frame(re, im, 4);
        collect(NB, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_three_four();
        test_neg_axis();
        test_corner();
        test_timing();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
